// File: rtl/move_legality_checker.sv
// move_legality_checker: sequential source/destination ownership check against board RAM.
// Optional feature macro MOVE_CHECK_KING_GUARD_EN rejects capture of the opponent king (code 3).
//
// state      | meaning
// S_IDLE     | ready for a request
// S_RD_SRC   | read strobe for source square
// S_WAIT_SRC | wait RD_LAT cycles, capture source code, decide next step
// S_RD_DST   | read strobe for destination square
// S_WAIT_DST | wait RD_LAT cycles, capture destination code, form verdict
// S_REJ      | one-cycle slot on the early-reject path, keeps verdict timing fixed
// S_DONE     | rsp_valid pulse
module move_legality_checker #(
    parameter int CODE_W         = 4,
    parameter int TYPES_PER_SIDE = 6,
    parameter int ADDR_W         = 6,
    parameter int RD_LAT         = 1,
    parameter int KING_IDX       = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_player,
    input  logic [ADDR_W-1:0] req_src,
    input  logic [ADDR_W-1:0] req_dst,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [CODE_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic              rsp_ok,
    output logic [1:0]        rsp_code,
    output logic [CODE_W-1:0] rsp_src_piece
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_SRC   = 3'd1;
    localparam logic [2:0] S_WAIT_SRC = 3'd2;
    localparam logic [2:0] S_RD_DST   = 3'd3;
    localparam logic [2:0] S_WAIT_DST = 3'd4;
    localparam logic [2:0] S_REJ      = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [1:0] RSP_OK          = 2'd0;
    localparam logic [1:0] RSP_SRC_NOT_OWN = 2'd1;
    localparam logic [1:0] RSP_DST_BLOCKED = 2'd2;

    // Ranges are compared one bit wider than the code so 2*T never wraps.
    localparam logic [CODE_W:0] BLK_LO = (CODE_W+1)'(1);
    localparam logic [CODE_W:0] BLK_HI = (CODE_W+1)'(TYPES_PER_SIDE);
    localparam logic [CODE_W:0] WHT_LO = (CODE_W+1)'(TYPES_PER_SIDE + 1);
    localparam logic [CODE_W:0] WHT_HI = (CODE_W+1)'(2 * TYPES_PER_SIDE);

    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

`ifdef MOVE_CHECK_KING_GUARD_EN
    localparam logic [1:0]      RSP_DST_KING = 2'd3;
    localparam logic [CODE_W:0] KING_BLK     = (CODE_W+1)'(KING_IDX);
    localparam logic [CODE_W:0] KING_WHT     = (CODE_W+1)'(TYPES_PER_SIDE + KING_IDX);
`endif

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_chk
        $error("move_legality_checker: RD_LAT must be 1..3");
    end
    if (KING_IDX < 1 || KING_IDX > TYPES_PER_SIDE) begin : g_king_chk
        $error("move_legality_checker: KING_IDX must be 1..TYPES_PER_SIDE");
    end

    function automatic logic owns(input logic pl, input logic [CODE_W-1:0] c);
        logic [CODE_W:0] cw;
        cw = {1'b0, c};
        if (pl) owns = (cw >= WHT_LO) && (cw <= WHT_HI);
        else    owns = (cw >= BLK_LO) && (cw <= BLK_HI);
    endfunction

    function automatic logic [1:0] dst_verdict(input logic pl, input logic [CODE_W-1:0] c);
        logic [CODE_W:0] cw;
        cw          = {1'b0, c};
        dst_verdict = RSP_OK;
        if (owns(pl, c) || (cw > WHT_HI)) dst_verdict = RSP_DST_BLOCKED;
`ifdef MOVE_CHECK_KING_GUARD_EN
        else if (cw == (pl ? KING_BLK : KING_WHT)) dst_verdict = RSP_DST_KING;
`endif
    endfunction

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              player_q, player_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CODE_W-1:0] piece_q, piece_d;
    logic [1:0]        code_q, code_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_ok_q, rsp_ok_d;
    logic [1:0]        rsp_code_q, rsp_code_d;
    logic [CODE_W-1:0] rsp_piece_q, rsp_piece_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        player_d = player_q;
        src_d    = src_q;
        dst_d    = dst_q;
        piece_d  = piece_q;
        code_d   = code_q;
        rd_en_d  = 1'b0;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    player_d = req_player;
                    src_d    = req_src;
                    dst_d    = req_dst;
                    rd_en_d  = 1'b1;
                    addr_d   = req_src;
                    state_d  = S_RD_SRC;
                end
            end
            S_RD_SRC: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT_SRC;
            end
            S_WAIT_SRC: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    piece_d = mem_rdata;
                    if (!owns(player_q, mem_rdata)) begin
                        code_d  = RSP_SRC_NOT_OWN;
                        state_d = S_REJ;
                    end else if (src_q == dst_q) begin
                        code_d  = RSP_DST_BLOCKED;
                        state_d = S_REJ;
                    end else begin
                        rd_en_d = 1'b1;
                        addr_d  = dst_q;
                        state_d = S_RD_DST;
                    end
                end
            end
            S_RD_DST: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT_DST;
            end
            S_WAIT_DST: begin
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    code_d  = dst_verdict(player_q, mem_rdata);
                    state_d = S_DONE;
                end
            end
            S_REJ:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Verdict outputs load on the edge into DONE and hold until the next verdict.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_ok_d    = rsp_ok_q;
        rsp_code_d  = rsp_code_q;
        rsp_piece_d = rsp_piece_q;
        if (state_d == S_DONE) begin
            rsp_valid_d = 1'b1;
            rsp_ok_d    = (code_d == RSP_OK);
            rsp_code_d  = code_d;
            rsp_piece_d = piece_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            player_q    <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            piece_q     <= '0;
            code_q      <= 2'd0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ok_q    <= 1'b0;
            rsp_code_q  <= 2'd0;
            rsp_piece_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            player_q    <= player_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            piece_q     <= piece_d;
            code_q      <= code_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_code_q  <= rsp_code_d;
            rsp_piece_q <= rsp_piece_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign mem_rd_en     = rd_en_q;
    assign mem_addr      = addr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_ok        = rsp_ok_q;
    assign rsp_code      = rsp_code_q;
    assign rsp_src_piece = rsp_piece_q;

endmodule

// File: tb/tb_move_legality_checker.sv
// Directed bench for move_legality_checker: RD_LAT=1 instance for verdicts/timing, RD_LAT=3 for back-to-back.
// Expected king-capture code follows MOVE_CHECK_KING_GUARD_EN.
module tb_move_legality_checker;

    logic clk = 1'b0;
    logic resetn;
    initial forever #5 clk = ~clk;

`ifdef MOVE_CHECK_KING_GUARD_EN
    localparam logic [1:0] KING_EXP = 2'd3;
`else
    localparam logic [1:0] KING_EXP = 2'd0;
`endif

    logic       req_valid_a, req_ready_a, req_player_a;
    logic [5:0] req_src_a, req_dst_a, mem_addr_a;
    logic       mem_rd_en_a, rsp_valid_a, rsp_ok_a;
    logic [3:0] mem_rdata_a, rsp_src_piece_a;
    logic [1:0] rsp_code_a;

    logic       req_valid_b, req_ready_b, req_player_b;
    logic [5:0] req_src_b, req_dst_b, mem_addr_b;
    logic       mem_rd_en_b, rsp_valid_b, rsp_ok_b;
    logic [3:0] mem_rdata_b, rsp_src_piece_b;
    logic [1:0] rsp_code_b;

    move_legality_checker #(.CODE_W(4), .TYPES_PER_SIDE(6), .ADDR_W(6), .RD_LAT(1), .KING_IDX(6)) dut_a (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_player(req_player_a),
        .req_src(req_src_a), .req_dst(req_dst_a),
        .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ok(rsp_ok_a), .rsp_code(rsp_code_a), .rsp_src_piece(rsp_src_piece_a)
    );

    move_legality_checker #(.CODE_W(4), .TYPES_PER_SIDE(6), .ADDR_W(6), .RD_LAT(3), .KING_IDX(6)) dut_b (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_player(req_player_b),
        .req_src(req_src_b), .req_dst(req_dst_b),
        .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ok(rsp_ok_b), .rsp_code(rsp_code_b), .rsp_src_piece(rsp_src_piece_b)
    );

    // Board RAM models: data valid only in the cycle RD_LAT after the strobe, garbage (0xD) otherwise.
    logic [3:0] board [64];
    logic       vld_a = 1'b0;
    logic [3:0] dat_a = 4'h0;
    logic [2:0] vld_b = 3'b000;
    logic [3:0] dat_b [3];

    always @(posedge clk) begin
        vld_a <= mem_rd_en_a;
        dat_a <= board[mem_addr_a];
        vld_b <= {vld_b[1:0], mem_rd_en_b};
        dat_b[0] <= board[mem_addr_b];
        dat_b[1] <= dat_b[0];
        dat_b[2] <= dat_b[1];
    end
    assign mem_rdata_a = vld_a ? dat_a : 4'hD;
    assign mem_rdata_b = vld_b[2] ? dat_b[2] : 4'hD;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_a(input string tag, input logic pl, input logic [5:0] s, input logic [5:0] d,
                         input logic [1:0] ec, input logic [3:0] ep, input int e_lat, input int e_reads);
        int         rsp_cyc, pulses, reads;
        logic [5:0] a1, a2;
        logic       ok_c;
        logic [1:0] code_c;
        logic [3:0] piece_c;
        rsp_cyc = 0; pulses = 0; reads = 0; a1 = '0; a2 = '0;
        ok_c = 1'b0; code_c = 2'd0; piece_c = 4'd0;
        check({tag, " ready"}, 32'(req_ready_a), 32'd1);
        req_player_a = pl; req_src_a = s; req_dst_a = d; req_valid_a = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            req_valid_a = 1'b0;
            req_src_a   = ~s;
            req_dst_a   = ~d;
            req_player_a = ~pl;
            if (mem_rd_en_a) begin
                reads++;
                if (reads == 1) a1 = mem_addr_a;
                else a2 = mem_addr_a;
            end
            if (rsp_valid_a) begin
                pulses++;
                if (rsp_cyc == 0) begin
                    rsp_cyc = i; ok_c = rsp_ok_a; code_c = rsp_code_a; piece_c = rsp_src_piece_a;
                end
            end
        end
        check({tag, " latency"}, 32'(rsp_cyc), 32'(e_lat));
        check({tag, " pulses"}, 32'(pulses), 32'd1);
        check({tag, " reads"}, 32'(reads), 32'(e_reads));
        check({tag, " src addr"}, 32'(a1), 32'(s));
        if (e_reads == 2) check({tag, " dst addr"}, 32'(a2), 32'(d));
        check({tag, " code"}, 32'(code_c), 32'(ec));
        check({tag, " ok"}, 32'(ok_c), 32'(ec == 2'd0));
        check({tag, " piece"}, 32'(piece_c), 32'(ep));
        check({tag, " code hold"}, 32'(rsp_code_a), 32'(ec));
        check({tag, " piece hold"}, 32'(rsp_src_piece_a), 32'(ep));
    endtask

    initial begin
        int         accepts, acc2, nrd, nr, nres;
        int         rdc [4];
        int         rc [2];

        for (int k = 0; k < 64; k++) board[k] = 4'd0;
        board[12] = 4'd3;  board[20] = 4'd0;  board[30] = 4'd2;  board[31] = 4'd0;
        board[32] = 4'd13; board[33] = 4'd6;  board[34] = 4'd4;  board[7]  = 4'd5;
        board[40] = 4'd12; board[41] = 4'd7;  board[42] = 4'd9;  board[43] = 4'd6;
        board[44] = 4'd15; board[46] = 4'd8;  board[47] = 4'd1;  board[48] = 4'd7;

        resetn = 1'b0;
        req_valid_a = 1'b0; req_player_a = 1'b0; req_src_a = '0; req_dst_a = '0;
        req_valid_b = 1'b0; req_player_b = 1'b0; req_src_b = '0; req_dst_b = '0;
        #2;
        check("rst ready", 32'(req_ready_a), 32'd1);
        check("rst rd_en", 32'(mem_rd_en_a), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst code", 32'(rsp_code_a), 32'd0);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        run_a("full p0",      1'b0, 6'd12, 6'd20, 2'd0, 4'd3,  5, 2);

        // Reset in WAIT_SRC: outputs clear immediately, in-flight read yields no verdict.
        req_player_a = 1'b0; req_src_a = 6'd12; req_dst_a = 6'd20; req_valid_a = 1'b1;
        @(posedge clk); #1; req_valid_a = 1'b0;
        @(posedge clk); #1;
        #2 resetn = 1'b0;
        #1;
        check("midrst ready", 32'(req_ready_a), 32'd1);
        check("midrst rd_en", 32'(mem_rd_en_a), 32'd0);
        check("midrst addr", 32'(mem_addr_a), 32'd0);
        check("midrst rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("midrst ok", 32'(rsp_ok_a), 32'd0);
        check("midrst code", 32'(rsp_code_a), 32'd0);
        check("midrst piece", 32'(rsp_src_piece_a), 32'd0);
        #2 resetn = 1'b1;
        nres = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid_a) nres++;
        end
        check("midrst no rsp", 32'(nres), 32'd0);

        run_a("p1 src black",    1'b1, 6'd30, 6'd20, 2'd1, 4'd2,  4, 1);
        run_a("p1 src empty",    1'b1, 6'd31, 6'd20, 2'd1, 4'd0,  4, 1);
        run_a("p1 src 13",       1'b1, 6'd32, 6'd20, 2'd1, 4'd13, 4, 1);
        run_a("p0 dst own",      1'b0, 6'd33, 6'd34, 2'd2, 4'd6,  5, 2);
        run_a("p0 src==dst",     1'b0, 6'd7,  6'd7,  2'd2, 4'd5,  4, 1);
        run_a("p0 dst wking",    1'b0, 6'd12, 6'd40, KING_EXP, 4'd3, 5, 2);
        run_a("p0 dst 7",        1'b0, 6'd12, 6'd41, 2'd0, 4'd3,  5, 2);
        run_a("p1 dst bking",    1'b1, 6'd42, 6'd43, KING_EXP, 4'd9, 5, 2);
        run_a("p1 dst illegal",  1'b1, 6'd42, 6'd44, 2'd2, 4'd9,  5, 2);
        run_a("p1 dst own king", 1'b1, 6'd42, 6'd40, 2'd2, 4'd9,  5, 2);
        run_a("p0 nonown s==d",  1'b0, 6'd46, 6'd46, 2'd1, 4'd8,  4, 1);
        run_a("p0 src 1",        1'b0, 6'd47, 6'd42, 2'd0, 4'd1,  5, 2);
        run_a("p1 src 7",        1'b1, 6'd48, 6'd12, 2'd0, 4'd7,  5, 2);
        run_a("p1 src 12",       1'b1, 6'd40, 6'd20, 2'd0, 4'd12, 5, 2);

        // RD_LAT=3, request held across two transactions.
        check("b ready", 32'(req_ready_b), 32'd1);
        req_player_b = 1'b0; req_src_b = 6'd12; req_dst_b = 6'd20; req_valid_b = 1'b1;
        accepts = 1; acc2 = 0; nrd = 0; nr = 0;
        for (int k = 0; k < 4; k++) rdc[k] = 0;
        rc[0] = 0; rc[1] = 0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            if (accepts == 2) req_valid_b = 1'b0;
            if (req_valid_b && req_ready_b) begin
                accepts++;
                acc2 = i;
            end
            if (mem_rd_en_b) begin
                if (nrd < 4) rdc[nrd] = i;
                nrd++;
            end
            if (rsp_valid_b) begin
                if (nr < 2) rc[nr] = i;
                nr++;
                check("b code", 32'(rsp_code_b), 32'd0);
                check("b ok", 32'(rsp_ok_b), 32'd1);
                check("b piece", 32'(rsp_src_piece_b), 32'd3);
            end
        end
        check("b second accept", 32'(acc2), 32'd10);
        check("b reads", 32'(nrd), 32'd4);
        check("b rd cyc0", 32'(rdc[0]), 32'd1);
        check("b rd cyc1", 32'(rdc[1]), 32'd5);
        check("b rd cyc2", 32'(rdc[2]), 32'd11);
        check("b rd cyc3", 32'(rdc[3]), 32'd15);
        check("b rsp count", 32'(nr), 32'd2);
        check("b rsp1 cyc", 32'(rc[0]), 32'd9);
        check("b rsp spacing", 32'(rc[1] - rc[0]), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
